maxcut_seq: RTL and testbench

//   Hardware max-cut sequencer driving the ising_axi register interface. Host loads an edge list,

---
 rtl/maxcut_seq_if.sv | 26 ++
 rtl/maxcut_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_maxcut_seq.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxcut_seq_if.sv
// Register-port bundle between the max-cut sequencer and the ising_axi block.
// The sequencer issues one register write per strobe and one phase read address
// per cycle; read data returns one cycle after the address.
interface maxcut_seq_if;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic [31:0] araddr;
  logic [31:0] rdata;

  modport master (
    output wready,
    output wr_addr,
    output wdata,
    output araddr,
    input  rdata
  );

  modport slave (
    input  wready,
    input  wr_addr,
    input  wdata,
    input  araddr,
    output rdata
  );
endinterface

// File: rtl/maxcut_seq.sv
// Max-cut sequencer: programs the ising array with a field node and an edge list,
// runs a fixed number of anneals, reads back every spin phase, scores the cut of
// each run on-chip and keeps the best cut together with its spin vector.
module maxcut_seq #(
  parameter int                     N                = 8,
  parameter int                     NUM_WEIGHTS      = 3,
  parameter int                     MAX_EDGES        = 32,
  parameter logic [NUM_WEIGHTS-1:0] CUT_WEIGHT       = 3'b001,
  parameter logic [NUM_WEIGHTS-1:0] FIELD_WEIGHT     = 3'b100,
  parameter int                     CTR_CUTOFF       = 4,
  parameter int                     CTR_MAX          = 8,
  parameter int                     RUN_CYCLES       = 600,
  parameter int                     NUM_RUNS         = 4,
  parameter logic [31:0]            START_ADDR       = 32'h0000_0000,
  parameter logic [31:0]            CTR_CUTOFF_ADDR  = 32'h0000_0004,
  parameter logic [31:0]            CTR_MAX_ADDR     = 32'h0000_0008,
  parameter logic [31:0]            PHASE_ADDR_BASE  = 32'h0000_0100,
  parameter logic [31:0]            WEIGHT_ADDR_BASE = 32'h0001_0000,
  localparam int                    IW               = $clog2(N),
  localparam int                    EW               = $clog2(MAX_EDGES),
  localparam int                    CW               = EW + 1,
  localparam int                    RW               = $clog2(NUM_RUNS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [EW-1:0] cfg_idx,
  input  logic [IW-1:0] cfg_u,
  input  logic [IW-1:0] cfg_v,
  input  logic [CW-1:0] num_edges,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] best_cut,
  output logic [N-1:0]  best_spins,
  output logic [RW-1:0] runs_done,
  maxcut_seq_if.master  axi
);

  localparam int CNT_W = 16;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CTR     = 4'd1;
  localparam logic [3:0] S_FIELD   = 4'd2;
  localparam logic [3:0] S_EDGE    = 4'd3;
  localparam logic [3:0] S_RUN_ON  = 4'd4;
  localparam logic [3:0] S_WAIT    = 4'd5;
  localparam logic [3:0] S_RUN_OFF = 4'd6;
  localparam logic [3:0] S_READ    = 4'd7;
  localparam logic [3:0] S_SCORE   = 4'd8;
  localparam logic [3:0] S_UPDATE  = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    ne_q, ne_d;
  logic [CW-1:0]    cut_q, cut_d;
  logic [N-1:0]     spin_q, spin_d;
  logic [CW-1:0]    best_cut_q, best_cut_d;
  logic [N-1:0]     best_spins_q, best_spins_d;
  logic [RW-1:0]    runs_done_q, runs_done_d;

  logic [2*IW-1:0]  edge_tbl_q [MAX_EDGES];
  logic             tbl_we;
  logic [2*IW-1:0]  sel_edge;
  logic [IW-1:0]    sel_u, sel_v, sel_lo, sel_hi;
  logic [IW-1:0]    rd_k;

  logic             wr_en_c;
  logic [31:0]      wr_addr_c, wdata_c, araddr_c;

  // Weight register address for the coupling between spins i and j (i < j)
  function automatic logic [31:0] weight_addr(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return WEIGHT_ADDR_BASE + (32'(i) << 2) + (32'(j) << 13);
  endfunction

  assign tbl_we   = cfg_we && (state_q == S_IDLE);
  assign sel_edge = edge_tbl_q[idx_q[EW-1:0]];
  assign sel_u    = sel_edge[2*IW-1:IW];
  assign sel_v    = sel_edge[IW-1:0];
  assign sel_lo   = (sel_u < sel_v) ? sel_u : sel_v;
  assign sel_hi   = (sel_u < sel_v) ? sel_v : sel_u;
  assign rd_k     = IW'(idx_q - 16'd1);

  // Edge table accepts host writes only while the sequencer is idle
  always_ff @(posedge clk) begin
    if (tbl_we) edge_tbl_q[cfg_idx] <= {cfg_u, cfg_v};
  end

  // Next-state, register-write and phase-read generation for the whole sequence
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ne_d         = ne_q;
    cut_d        = cut_q;
    spin_d       = spin_q;
    best_cut_d   = best_cut_q;
    best_spins_d = best_spins_q;
    runs_done_d  = runs_done_q;
    wr_en_c      = 1'b0;
    wr_addr_c    = 32'd0;
    wdata_c      = 32'd0;
    araddr_c     = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ne_d         = (num_edges > CW'(MAX_EDGES)) ? CW'(MAX_EDGES) : num_edges;
          best_cut_d   = '0;
          best_spins_d = '0;
          runs_done_d  = '0;
          idx_d        = '0;
          state_d      = S_CTR;
        end
      end
      S_CTR: begin
        wr_en_c = 1'b1;
        if (idx_q == '0) begin
          wr_addr_c = CTR_CUTOFF_ADDR;
          wdata_c   = 32'(CTR_CUTOFF);
          idx_d     = 16'd1;
        end else begin
          wr_addr_c = CTR_MAX_ADDR;
          wdata_c   = 32'(CTR_MAX);
          idx_d     = '0;
          state_d   = S_FIELD;
        end
      end
      S_FIELD: begin
        wr_en_c   = 1'b1;
        wr_addr_c = weight_addr(idx_q[IW-1:0], IW'(N - 1));
        wdata_c   = 32'(FIELD_WEIGHT);
        idx_d     = idx_q + 16'd1;
        if (idx_q == CNT_W'(N - 2)) begin
          idx_d   = '0;
          state_d = (ne_q == '0) ? S_RUN_ON : S_EDGE;
        end
      end
      S_EDGE: begin
        wr_en_c   = 1'b1;
        wr_addr_c = weight_addr(sel_lo, sel_hi);
        wdata_c   = 32'(CUT_WEIGHT);
        idx_d     = idx_q + 16'd1;
        if (idx_q == CNT_W'(ne_q) - 16'd1) begin
          idx_d   = '0;
          state_d = S_RUN_ON;
        end
      end
      S_RUN_ON: begin
        wr_en_c   = 1'b1;
        wr_addr_c = START_ADDR;
        wdata_c   = 32'd1;
        idx_d     = 16'd1;
        state_d   = (RUN_CYCLES <= 1) ? S_RUN_OFF : S_WAIT;
      end
      S_WAIT: begin
        idx_d = idx_q + 16'd1;
        if (idx_q == CNT_W'(RUN_CYCLES - 1)) state_d = S_RUN_OFF;
      end
      S_RUN_OFF: begin
        wr_en_c   = 1'b1;
        wr_addr_c = START_ADDR;
        wdata_c   = 32'd0;
        idx_d     = '0;
        state_d   = S_READ;
      end
      S_READ: begin
        if (idx_q < CNT_W'(N)) araddr_c = PHASE_ADDR_BASE + (32'(idx_q) << 2);
        if (idx_q != '0) spin_d[rd_k] = (axi.rdata >= 32'(CTR_CUTOFF));
        idx_d = idx_q + 16'd1;
        if (idx_q == CNT_W'(N)) begin
          idx_d   = '0;
          cut_d   = '0;
          state_d = (ne_q == '0) ? S_UPDATE : S_SCORE;
        end
      end
      S_SCORE: begin
        cut_d = cut_q + CW'(spin_q[sel_u] ^ spin_q[sel_v]);
        idx_d = idx_q + 16'd1;
        if (idx_q == CNT_W'(ne_q) - 16'd1) begin
          idx_d   = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        runs_done_d = runs_done_q + RW'(1);
        if ((runs_done_q == '0) || (cut_q > best_cut_q)) begin
          best_cut_d   = cut_q;
          best_spins_d = spin_q ^ {N{spin_q[N-1]}};
        end
        state_d = (runs_done_d < RW'(NUM_RUNS)) ? S_RUN_ON : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state; reset aborts at once and leaves the ising array running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ne_q         <= '0;
      cut_q        <= '0;
      spin_q       <= '0;
      best_cut_q   <= '0;
      best_spins_q <= '0;
      runs_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ne_q         <= ne_d;
      cut_q        <= cut_d;
      spin_q       <= spin_d;
      best_cut_q   <= best_cut_d;
      best_spins_q <= best_spins_d;
      runs_done_q  <= runs_done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign best_cut    = best_cut_q;
  assign best_spins  = best_spins_q;
  assign runs_done   = runs_done_q;
  assign axi.wready  = wr_en_c;
  assign axi.wr_addr = wr_addr_c;
  assign axi.wdata   = wdata_c;
  assign axi.araddr  = araddr_c;

endmodule

// File: tb/tb_maxcut_seq.sv
// Bench for maxcut_seq: a small ising_axi stand-in returns per-run phase values,
// expected register writes and final results are queued when a start is issued
// and checked as the sequencer produces them.
module tb_maxcut_seq;
  localparam int          N                = 8;
  localparam int          MAX_EDGES        = 32;
  localparam int          RUN_CYCLES       = 600;
  localparam int          NUM_RUNS         = 4;
  localparam logic [31:0] START_ADDR       = 32'h0000_0000;
  localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004;
  localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008;
  localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_0100;
  localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         cut;
    logic [7:0] spins;
    int         runs;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [4:0] cfg_idx;
  logic [2:0] cfg_u, cfg_v;
  logic [5:0] num_edges;
  logic       start;
  logic       busy, done;
  logic [5:0] best_cut;
  logic [7:0] best_spins;
  logic [2:0] runs_done;

  maxcut_seq_if axi_bus ();

  maxcut_seq #(
    .N(N), .NUM_WEIGHTS(3), .MAX_EDGES(MAX_EDGES), .CUT_WEIGHT(3'b001), .FIELD_WEIGHT(3'b100),
    .CTR_CUTOFF(4), .CTR_MAX(8), .RUN_CYCLES(RUN_CYCLES), .NUM_RUNS(NUM_RUNS),
    .START_ADDR(START_ADDR), .CTR_CUTOFF_ADDR(CTR_CUTOFF_ADDR), .CTR_MAX_ADDR(CTR_MAX_ADDR),
    .PHASE_ADDR_BASE(PHASE_ADDR_BASE), .WEIGHT_ADDR_BASE(WEIGHT_ADDR_BASE)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_u(cfg_u), .cfg_v(cfg_v),
    .num_edges(num_edges), .start(start), .busy(busy), .done(done), .best_cut(best_cut),
    .best_spins(best_spins), .runs_done(runs_done), .axi(axi_bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         run_ctr = 0;
  int         start_cyc = 0;
  int         tb_u [MAX_EDGES];
  int         tb_v [MAX_EDGES];
  logic [7:0] run_spins [NUM_RUNS];
  wr_t        exp_wr_q [$];
  res_t       exp_res_q [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] waddr(input int i, input int j);
    return WEIGHT_ADDR_BASE + 32'(i * 4) + 32'(j * 8192);
  endfunction

  function automatic int busy_cycles(input int ne);
    return 2 + (N - 1) + ne + NUM_RUNS * (RUN_CYCLES + N + 3 + ne) + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ising_axi stand-in: registered phase read, spin value chosen by the current run
  always @(posedge clk) begin
    int k, r;
    logic s;
    if (axi_bus.araddr >= PHASE_ADDR_BASE && axi_bus.araddr < PHASE_ADDR_BASE + 32'(4 * N)) begin
      k = int'((axi_bus.araddr - PHASE_ADDR_BASE) >> 2);
      r = (run_ctr > 0) ? run_ctr - 1 : 0;
      if (r >= NUM_RUNS) r = NUM_RUNS - 1;
      s = run_spins[r][k];
      if (s) axi_bus.rdata <= (k % 2 == 1) ? 32'(8 + k) : 32'd4;
      else   axi_bus.rdata <= (k % 2 == 1) ? 32'd0 : 32'd3;
    end else begin
      axi_bus.rdata <= 32'hDEAD_BEEF;
    end
  end

  // Write monitor: every strobe must match the next queued register write
  always @(negedge clk) begin
    wr_t e;
    if (!rst && axi_bus.wready) begin
      checkOutput("write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        checkOutput("wr_addr", 64'(axi_bus.wr_addr), 64'(e.addr));
        checkOutput("wdata", 64'(axi_bus.wdata), 64'(e.data));
        if (e.addr == START_ADDR) begin
          if (e.data == 32'd1) begin
            run_ctr++;
            start_cyc = cyc;
          end else begin
            checkOutput("start_hold", 64'(cyc - start_cyc), 64'(RUN_CYCLES));
          end
        end
      end
    end
  end

  task automatic loadEdge(input int idx, input int u, input int v);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_idx = 5'(idx);
    cfg_u   = 3'(u);
    cfg_v   = 3'(v);
    tb_u[idx] = u;
    tb_v[idx] = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Queue the expected write trace and result, then pulse start
  task automatic applyStimulus(input int ne);
    int   ne_eff, best, c, lo, hi;
    logic [7:0] bs, s;
    res_t res;
    ne_eff = (ne > MAX_EDGES) ? MAX_EDGES : ne;
    exp_wr_q.push_back({CTR_CUTOFF_ADDR, 32'd4});
    exp_wr_q.push_back({CTR_MAX_ADDR, 32'd8});
    for (int i = 0; i < N - 1; i++) exp_wr_q.push_back({waddr(i, N - 1), 32'd4});
    for (int k = 0; k < ne_eff; k++) begin
      lo = (tb_u[k] < tb_v[k]) ? tb_u[k] : tb_v[k];
      hi = (tb_u[k] < tb_v[k]) ? tb_v[k] : tb_u[k];
      exp_wr_q.push_back({waddr(lo, hi), 32'd1});
    end
    for (int r = 0; r < NUM_RUNS; r++) begin
      exp_wr_q.push_back({START_ADDR, 32'd1});
      exp_wr_q.push_back({START_ADDR, 32'd0});
    end
    best = 0;
    bs   = 8'h00;
    for (int r = 0; r < NUM_RUNS; r++) begin
      s = run_spins[r];
      c = 0;
      for (int k = 0; k < ne_eff; k++) if (s[tb_u[k]] != s[tb_v[k]]) c++;
      if (r == 0 || c > best) begin
        best = c;
        bs   = s ^ {8{s[7]}};
      end
    end
    res.cut   = best;
    res.spins = bs;
    res.runs  = NUM_RUNS;
    exp_res_q.push_back(res);
    run_ctr = 0;
    @(negedge clk);
    num_edges = 6'(ne);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, optionally poking start/cfg_we while busy, and count busy cycles
  task automatic waitDone(input int exp_busy, input int poke_at);
    int cnt;
    bit seen;
    res_t res;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (busy) cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cnt == poke_at) begin
        start   = 1'b1;
        cfg_we  = 1'b1;
        cfg_idx = 5'd0;
        cfg_u   = 3'd2;
        cfg_v   = 3'd3;
      end else begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    checkOutput("done_seen", 64'(seen), 64'd1);
    checkOutput("busy_cycles", 64'(cnt), 64'(exp_busy));
    checkOutput("result_queued", 64'(exp_res_q.size()), 64'd1);
    if (exp_res_q.size() != 0) begin
      res = exp_res_q.pop_front();
      checkOutput("best_cut", 64'(best_cut), 64'(res.cut));
      checkOutput("best_spins", 64'(best_spins), 64'(res.spins));
      checkOutput("runs_done", 64'(runs_done), 64'(res.runs));
    end
    checkOutput("writes_left", 64'(exp_wr_q.size()), 64'd0);
  endtask

  initial begin
    bit reached;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_u     = '0;
    cfg_v     = '0;
    num_edges = '0;
    start     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_best_cut", 64'(best_cut), 64'd0);
    checkOutput("rst_best_spins", 64'(best_spins), 64'd0);
    checkOutput("rst_runs_done", 64'(runs_done), 64'd0);
    checkOutput("rst_wready", 64'(axi_bus.wready), 64'd0);
    checkOutput("rst_araddr", 64'(axi_bus.araddr), 64'd0);
    rst = 1'b0;

    // Graph A-E, two entries stored with endpoints reversed
    loadEdge(0, 0, 1);
    loadEdge(1, 4, 0);
    loadEdge(2, 1, 2);
    loadEdge(3, 3, 1);
    loadEdge(4, 2, 3);
    loadEdge(5, 3, 4);

    $display("[TB] six-edge graph, cuts 3/5/5/2, start and cfg_we poked while busy");
    run_spins[0] = 8'h08;
    run_spins[1] = 8'hED;
    run_spins[2] = 8'h0D;
    run_spins[3] = 8'h01;
    applyStimulus(6);
    waitDone(busy_cycles(6), 100);
    checkOutput("graph_best_cut", 64'(best_cut), 64'd5);
    checkOutput("graph_best_spins", 64'(best_spins), 64'h12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_pulse", 64'(done), 64'd0);
    checkOutput("start_at_done_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("still_idle", 64'(busy), 64'd0);

    $display("[TB] zero edges, first run loads best");
    run_spins[0] = 8'h81;
    run_spins[1] = 8'h00;
    run_spins[2] = 8'hFF;
    run_spins[3] = 8'h3C;
    applyStimulus(0);
    waitDone(busy_cycles(0), -1);
    @(negedge clk);
    checkOutput("idle_after_done", 64'(busy), 64'd0);

    $display("[TB] reset during wait");
    run_spins[0] = 8'hED;
    run_spins[1] = 8'h08;
    run_spins[2] = 8'h01;
    run_spins[3] = 8'h0D;
    applyStimulus(6);
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_ctr >= 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reached_run2", 64'(reached), 64'd1);
    repeat (50) @(negedge clk);
    checkOutput("pre_rst_runs_done", 64'(runs_done), 64'd1);
    checkOutput("pre_rst_best_cut", 64'(best_cut), 64'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_best_cut", 64'(best_cut), 64'd0);
    checkOutput("mid_rst_runs_done", 64'(runs_done), 64'd0);
    checkOutput("mid_rst_best_spins", 64'(best_spins), 64'd0);
    checkOutput("mid_rst_wready", 64'(axi_bus.wready), 64'd0);
    exp_wr_q.delete();
    exp_res_q.delete();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] full table, num_edges above depth, random spins");
    for (int k = 6; k < MAX_EDGES; k++) begin
      int u, v;
      u = k % 7;
      v = (k * 3 + 1) % 7;
      if (u == v) v = (u + 1) % 7;
      loadEdge(k, u, v);
    end
    for (int r = 0; r < NUM_RUNS; r++) run_spins[r] = 8'($urandom);
    applyStimulus(40);
    waitDone(busy_cycles(MAX_EDGES), -1);
    @(negedge clk);
    checkOutput("final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
